alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream operation present.
REQ-005 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-006 SHALL have port alu_func  input  RISCV::alu_func_t  operation select (ADD, SUB, OR, AND, NOP).
REQ-007 SHALL have port op_a  input  XLEN  first operand.
REQ-008 SHALL have port op_b  input  XLEN  second operand.
REQ-009 SHALL have port rd  input  5  destination register index.
REQ-010 SHALL have port reg_write  input  1  writeback enable.
REQ-011 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port out_result  output  XLEN  registered ALU result.
REQ-015 SHALL have port out_zero  output  1  out_result == 0.
REQ-016 SHALL have port out_rd  output  5  registered rd.
REQ-017 SHALL have port out_reg_write  output  1  registered writeback enable.

Function
REQ-018 SHALL hold at most two entries: main register (drives outputs) and skid register; transfers in order.
REQ-019 SHALL accept when in_valid && in_ready; drain when out_valid && out_ready.
REQ-020 SHALL drive in_ready = !skid_valid, from registered state only (no combinational path from out_ready).
REQ-021 SHALL compute at accept: ADD = op_a+op_b mod 2^XLEN; SUB = op_a-op_b mod 2^XLEN (two's complement); OR = op_a|op_b; AND = op_a&op_b.
REQ-022 SHALL treat NOP and any unlisted encoding as result 0, reg_write forced 0, entry still valid.
REQ-023 SHALL compute zero flag from stored result, travelling with the entry.
REQ-024 SHALL give latency 1: accept in cycle N -> out_valid in N+1 when main empty or drained in N.
REQ-025 SHALL, states by (main_valid, skid_valid): EMPTY(0,0), ONE(1,0), FULL(1,1); (0,1) unreachable.
REQ-026 SHALL in EMPTY: accept -> ONE with new entry in main.
REQ-027 SHALL in ONE: accept+drain -> ONE with new entry; accept only -> FULL, new entry in skid; drain only -> EMPTY.
REQ-028 SHALL in FULL: drain -> ONE, skid moves to main; no accept possible (in_ready=0).
REQ-029 SHALL on flush: next state EMPTY regardless of in_valid/out_ready same cycle; a simultaneous accept is discarded.
REQ-030 SHALL hold out_* stable while out_valid && !out_ready.
REQ-031 SHALL keep data registers unchanged when no transfer occurs (no gating on invalid bubbles required for correctness).

Reset
REQ-032 SHALL on rst_n=0 asynchronously clear main_valid and skid_valid; out_valid=0, in_ready=1.
REQ-033 SHALL on reset clear out_result=0, out_zero=1, out_rd=0, out_reg_write=0.
REQ-034 SHALL on reset assertion mid-operation discard held entries; first accept after release behaves as from EMPTY.

Verification
REQ-035 SHALL cover: ADD op_a=0xFFFFFFFF, op_b=1, rd=5, reg_write=1, out_ready=1 -> next cycle out_result=0, out_zero=1, out_rd=5, out_reg_write=1.
REQ-036 SHALL cover: SUB 3-5 -> out_result=0xFFFFFFFE, out_zero=0; OR 0xF0|0x0F -> 0xFF; AND 0xF0&0x0F -> 0, out_zero=1.
REQ-037 SHALL cover: out_ready=0, three back-to-back ADDs 1+1,2+2,3+3 -> in_ready drops after second accept, third held upstream; releasing out_ready yields 2,4,6 in order, no loss/duplication.
REQ-038 SHALL cover: FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and incoming entries never appear.
REQ-039 SHALL cover: NOP with reg_write=1, rd=7 -> out_result=0, out_reg_write=0, out_rd=7.
REQ-040 SHALL cover: rst_n asserted while FULL and mid-cycle (between edges) -> out_valid=0 immediately, out_result=0; then 10+20 ADD -> 30 one cycle later.

Source files
------------

// File: rtl/alu_exec_stage.sv
// ALU execute stage: one-cycle ALU with a two-entry (main + skid) output buffer.

package RISCV;
  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_OR  = 3'd3,
    ALU_AND = 3'd4
  } alu_func_t;
endpackage

module alu_exec_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  RISCV::alu_func_t        alu_func,
  input  logic [XLEN-1:0]         op_a,
  input  logic [XLEN-1:0]         op_b,
  input  logic [4:0]              rd,
  input  logic                    reg_write,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_result,
  output logic                    out_zero,
  output logic [4:0]              out_rd,
  output logic                    out_reg_write
);

  localparam int unsigned RD_W = 5;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic            accept;
  logic            drain;
  logic            load_main;
  logic            load_skid;
  logic            move_skid;

  logic [XLEN-1:0] new_result;
  logic            new_zero;
  logic            new_rw;

  logic [XLEN-1:0] skid_result;
  logic            skid_zero;
  logic [RD_W-1:0] skid_rd;
  logic            skid_rw;

  // Handshakes use only registered ready/valid, so no out_ready -> in_ready path.
  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // ALU result for the incoming operation; NOP and unknown encodings yield 0 with no writeback.
  always_comb begin
    new_result = '0;
    new_rw     = 1'b0;
    case (alu_func)
      RISCV::ALU_ADD: begin new_result = op_a + op_b; new_rw = reg_write; end
      RISCV::ALU_SUB: begin new_result = op_a - op_b; new_rw = reg_write; end
      RISCV::ALU_OR:  begin new_result = op_a | op_b; new_rw = reg_write; end
      RISCV::ALU_AND: begin new_result = op_a & op_b; new_rw = reg_write; end
      default: begin new_result = '0; new_rw = 1'b0; end
    endcase
    new_zero = (new_result == '0);
  end

  // Next-state and buffer-load decisions; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d   = S_ONE;
          load_main = 1'b1;
        end
      end
      S_ONE: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = S_FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (drain) begin
          state_d   = S_ONE;
          move_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) begin
      state_d   = S_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  // State register plus registered handshake outputs derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d != S_EMPTY);
      in_ready  <= (state_d != S_FULL);
    end
  end

  // Main entry drives the outputs; updated only on a load or skid promotion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result    <= '0;
      out_zero      <= 1'b1;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
    end else if (load_main) begin
      out_result    <= new_result;
      out_zero      <= new_zero;
      out_rd        <= rd;
      out_reg_write <= new_rw;
    end else if (move_skid) begin
      out_result    <= skid_result;
      out_zero      <= skid_zero;
      out_rd        <= skid_rd;
      out_reg_write <= skid_rw;
    end
  end

  // Skid entry captures an accept that arrives while main is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_result <= '0;
      skid_zero   <= 1'b1;
      skid_rd     <= '0;
      skid_rw     <= 1'b0;
    end else if (load_skid) begin
      skid_result <= new_result;
      skid_zero   <= new_zero;
      skid_rd     <= rd;
      skid_rw     <= new_rw;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: vector table, corner sequences, random run against a queue model.

module tb_alu_exec_stage;

  localparam int unsigned XLEN = 32;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  RISCV::alu_func_t       alu_func;
  logic [XLEN-1:0]        op_a;
  logic [XLEN-1:0]        op_b;
  logic [4:0]             rd;
  logic                   reg_write;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_result;
  logic                   out_zero;
  logic [4:0]             out_rd;
  logic                   out_reg_write;

  int n_total;
  int n_bad;

  alu_exec_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_func(alu_func), .op_a(op_a), .op_b(op_b), .rd(rd), .reg_write(reg_write),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_rd(out_rd), .out_reg_write(out_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] result;
    logic            zero;
    logic [4:0]      rd;
    logic            rw;
  } entry_t;

  typedef struct {
    logic [2:0]      func;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd;
    logic            rw;
    logic [XLEN-1:0] exp_result;
    logic            exp_zero;
    logic            exp_rw;
  } vec_t;

  entry_t model_q[$];

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: operation rules applied with plain arithmetic.
  function automatic entry_t ref_op(input logic [2:0] f, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b, input logic [4:0] r, input logic w);
    entry_t e;
    longint unsigned m;
    m = 64'h1_0000_0000;
    e.rd = r;
    e.rw = w;
    case (f)
      3'd1: e.result = XLEN'((longint'(a) + longint'(b)) % m);
      3'd2: e.result = XLEN'((longint'(a) + m - longint'(b)) % m);
      3'd3: e.result = a | b;
      3'd4: e.result = a & b;
      default: begin e.result = '0; e.rw = 1'b0; end
    endcase
    e.zero = (e.result == 0);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [2:0] f, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [4:0] r, input logic w);
    in_valid  = v;
    alu_func  = RISCV::alu_func_t'(f);
    op_a      = a;
    op_b      = b;
    rd        = r;
    reg_write = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input entry_t e);
    chk({name, ".valid"}, XLEN'(out_valid), 1);
    chk({name, ".result"}, out_result, e.result);
    chk({name, ".zero"}, XLEN'(out_zero), XLEN'(e.zero));
    chk({name, ".rd"}, XLEN'(out_rd), XLEN'(e.rd));
    chk({name, ".rw"}, XLEN'(out_reg_write), XLEN'(e.rw));
  endtask

  task automatic fill_full(input logic [XLEN-1:0] a0, input logic [XLEN-1:0] a1);
    out_ready = 1'b0;
    drive(1'b1, 3'd1, a0, 0, 5'd1, 1'b1); tick();
    drive(1'b1, 3'd1, a1, 0, 5'd2, 1'b1); tick();
    drive(1'b0, 3'd0, 0, 0, 5'd0, 1'b0);
    chk("fill.in_ready", XLEN'(in_ready), 0);
  endtask

  vec_t vecs[7];

  initial begin
    entry_t e;
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 0, 0, 5'd0, 1'b0);

    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 32'd0, 1'b1, 1'b1};
    vecs[1] = '{3'd2, 32'd3, 32'd5, 5'd6, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1};
    vecs[2] = '{3'd3, 32'hF0, 32'h0F, 5'd9, 1'b1, 32'hFF, 1'b0, 1'b1};
    vecs[3] = '{3'd4, 32'hF0, 32'h0F, 5'd10, 1'b0, 32'd0, 1'b1, 1'b0};
    vecs[4] = '{3'd0, 32'h1234, 32'h5678, 5'd7, 1'b1, 32'd0, 1'b1, 1'b0};
    vecs[5] = '{3'd6, 32'h1234, 32'h5678, 5'd3, 1'b1, 32'd0, 1'b1, 1'b0};
    vecs[6] = '{3'd1, 32'h7FFF_FFFF, 32'd1, 5'd31, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

    // Reset state
    #12;
    chk("rst.out_valid", XLEN'(out_valid), 0);
    chk("rst.in_ready", XLEN'(in_ready), 1);
    chk("rst.out_result", out_result, 0);
    chk("rst.out_zero", XLEN'(out_zero), 1);
    chk("rst.out_rd", XLEN'(out_rd), 0);
    chk("rst.out_rw", XLEN'(out_reg_write), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Vector table, one operation at a time with latency 1
    for (int i = 0; i < 7; i++) begin
      e.result = vecs[i].exp_result;
      e.zero   = vecs[i].exp_zero;
      e.rd     = vecs[i].rd;
      e.rw     = vecs[i].exp_rw;
      drive(1'b1, vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].rw);
      tick();
      chk_out($sformatf("vec%0d", i), e);
      drive(1'b0, 3'd0, 0, 0, 5'd0, 1'b0);
      tick();
      chk($sformatf("vec%0d.drained", i), XLEN'(out_valid), 0);
    end

    // Backpressure: three ADDs with out_ready low, then release
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 1, 1, 5'd1, 1'b1); tick();
    chk("bp.in_ready1", XLEN'(in_ready), 1);
    drive(1'b1, 3'd1, 2, 2, 5'd2, 1'b1); tick();
    chk("bp.in_ready2", XLEN'(in_ready), 0);
    chk("bp.hold0", out_result, 2);
    drive(1'b1, 3'd1, 3, 3, 5'd3, 1'b1); tick();
    chk("bp.in_ready3", XLEN'(in_ready), 0);
    chk("bp.hold1", out_result, 2);
    out_ready = 1'b1;
    tick();
    chk("bp.second", out_result, 4);
    chk("bp.in_ready4", XLEN'(in_ready), 1);
    tick();
    chk("bp.third", out_result, 6);
    chk("bp.third_rd", XLEN'(out_rd), 3);
    drive(1'b0, 3'd0, 0, 0, 5'd0, 1'b0);
    tick();
    chk("bp.empty", XLEN'(out_valid), 0);

    // Flush while FULL with a simultaneous incoming op
    fill_full(100, 200);
    flush = 1'b1;
    drive(1'b1, 3'd1, 55, 5, 5'd4, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, 3'd0, 0, 0, 5'd0, 1'b0);
    chk("flush.out_valid", XLEN'(out_valid), 0);
    chk("flush.in_ready", XLEN'(in_ready), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush.stays_empty", XLEN'(out_valid), 0);
    end

    // Asynchronous reset mid-cycle while FULL
    fill_full(7, 8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", XLEN'(out_valid), 0);
    chk("arst.out_result", out_result, 0);
    chk("arst.in_ready", XLEN'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'd1, 10, 20, 5'd12, 1'b1);
    tick();
    e = '{32'd30, 1'b0, 5'd12, 1'b1};
    chk_out("arst.first", e);
    drive(1'b0, 3'd0, 0, 0, 5'd0, 1'b0);
    tick();
    chk("arst.drained", XLEN'(out_valid), 0);

    // Random traffic vs queue model
    model_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic v, fl, rdy, acc, drn;
      logic [2:0] f;
      logic [XLEN-1:0] a, b;
      chk("rnd.in_ready", XLEN'(in_ready), XLEN'(model_q.size() < 2));
      chk("rnd.out_valid", XLEN'(out_valid), XLEN'(model_q.size() > 0));
      if (model_q.size() > 0) begin
        chk("rnd.result", out_result, model_q[0].result);
        chk("rnd.zero", XLEN'(out_zero), XLEN'(model_q[0].zero));
        chk("rnd.rd", XLEN'(out_rd), XLEN'(model_q[0].rd));
        chk("rnd.rw", XLEN'(out_reg_write), XLEN'(model_q[0].rw));
      end
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 40) == 0);
      f   = 3'($urandom_range(0, 7));
      a   = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 4)) : XLEN'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? a : XLEN'($urandom);
      drive(v, f, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      out_ready = rdy;
      flush     = fl;
      acc = v && (model_q.size() < 2);
      drn = rdy && (model_q.size() > 0);
      if (fl) begin
        model_q.delete();
      end else begin
        if (drn) void'(model_q.pop_front());
        if (acc) model_q.push_back(ref_op(f, a, b, rd, reg_write));
      end
      tick();
    end
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
